// File: rtl/fifo_ctrl16_pkg.sv
// Shared sizing and word types for the 16-deep streaming FIFO controller.
package fifo_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int LVL_W  = 5;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [LVL_W-1:0]  lvl_t;
endpackage

// File: rtl/fifo_ctrl16_if.sv
// Push/pop handshakes plus the RAM port bundle of the FIFO controller.
interface fifo_ctrl16_if;
    import fifo_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_data;
    logic  out_valid;
    logic  out_ready;
    word_t out_data;
    lvl_t  level;
    logic  mem_we;
    addr_t mem_waddr;
    word_t mem_wdata;
    logic  mem_re;
    addr_t mem_raddr;
    word_t mem_rdata;

    // master is the surrounding datapath (producer, consumer, RAM); slave is the controller.
    modport master (
        output in_valid, in_data, out_ready, mem_rdata,
        input  in_ready, out_valid, out_data, level,
               mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
    );

    modport slave (
        input  in_valid, in_data, out_ready, mem_rdata,
        output in_ready, out_valid, out_data, level,
               mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
    );
endinterface

// File: rtl/fifo_ctrl16.sv
// FIFO controller driving a 16x16 negedge-sampled dual-port RAM; 17 words total
// (16 in RAM plus the registered output word).
module fifo_ctrl16
    import fifo_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    fifo_ctrl16_if.slave bus
);

    addr_t wptr_q, wptr_d;
    addr_t rptr_q, rptr_d;
    lvl_t  cnt_q, cnt_d;
    logic  oval_q, oval_d;
    word_t odata_q, odata_d;

    logic clear;
    logic inReady;
    logic push;
    logic load;

    assign clear   = ~rst_n | flush;
    assign inReady = (cnt_q != lvl_t'(DEPTH));
    // Transfers coinciding with reset/flush are discarded, so keep the RAM ports idle then.
    assign push    = bus.in_valid & inReady & ~clear;
    assign load    = (cnt_q != '0) & (~oval_q | bus.out_ready) & ~clear;

    assign bus.in_ready  = inReady;
    assign bus.out_valid = oval_q;
    assign bus.out_data  = odata_q;
    assign bus.level     = cnt_q + lvl_t'(oval_q);
    assign bus.mem_we    = push;
    assign bus.mem_waddr = wptr_q;
    assign bus.mem_wdata = bus.in_data;
    assign bus.mem_re    = load;
    assign bus.mem_raddr = rptr_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        oval_d  = oval_q;
        odata_d = odata_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            cnt_d   = '0;
            oval_d  = 1'b0;
            odata_d = '0;
        end else begin
            wptr_d = wptr_q + addr_t'(push);
            rptr_d = rptr_q + addr_t'(load);
            cnt_d  = cnt_q + lvl_t'(push) - lvl_t'(load);
            // mem_rdata was captured by the RAM at the preceding negedge for rptr_q.
            if (load) begin
                odata_d = bus.mem_rdata;
                oval_d  = 1'b1;
            end else if (bus.out_ready) begin
                oval_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            oval_q  <= 1'b0;
            odata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            oval_q  <= oval_d;
            odata_q <= odata_d;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl16.sv
// Self-checking bench for fifo_ctrl16 with a behavioural negedge RAM and a word scoreboard.
module tb_fifo_ctrl16;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   tests = 0;
    int   fails = 0;

    int    mcnt = 0;
    bit    mov  = 1'b0;
    word_t sb[$];
    word_t ram[DEPTH];

    fifo_ctrl16_if bus();

    fifo_ctrl16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // RAM returns old data on a same-address read/write because of the non-blocking updates.
    always @(negedge clk) begin
        if (bus.mem_we) ram[bus.mem_waddr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_raddr];
    end

    task automatic drive(input logic v, input word_t d, input logic r, input logic f, input logic rn);
        #1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        flush         = f;
        rst_n         = rn;
        #3;
    endtask

    task automatic advance();
        bit pushM, loadM, takeM;
        @(posedge clk);
        if (!rst_n || flush) begin
            mcnt = 0;
            mov  = 1'b0;
            sb.delete();
        end else begin
            pushM = bus.in_valid && (mcnt != DEPTH);
            loadM = (mcnt != 0) && (!mov || bus.out_ready);
            takeM = mov && bus.out_ready;
            if (takeM) void'(sb.pop_front());
            if (pushM) sb.push_back(bus.in_data);
            mcnt = mcnt + int'(pushM) - int'(loadM);
            if (loadM) mov = 1'b1;
            else if (bus.out_ready) mov = 1'b0;
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        advance();
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        tests++; if (bus.level !== 5'd0) begin fails++; $display("[TB] FAIL reset_level: got %0d want 0", bus.level); end
        tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        tests++; if (bus.out_data !== 16'h0000) begin fails++; $display("[TB] FAIL reset_out_data: got %h want 0000", bus.out_data); end
        advance();
    endtask

    task automatic test_single();
        drive(1'b1, 16'hA001, 1'b0, 1'b0, 1'b1);
        tests++; if (bus.mem_we !== 1'b1) begin fails++; $display("[TB] FAIL single_mem_we: got %b want 1", bus.mem_we); end
        tests++; if (bus.mem_waddr !== 4'd0) begin fails++; $display("[TB] FAIL single_waddr: got %0d want 0", bus.mem_waddr); end
        tests++; if (bus.mem_wdata !== 16'hA001) begin fails++; $display("[TB] FAIL single_wdata: got %h want a001", bus.mem_wdata); end
        advance();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tests++; if (bus.mem_re !== 1'b1) begin fails++; $display("[TB] FAIL single_mem_re: got %b want 1", bus.mem_re); end
        tests++; if (bus.mem_raddr !== 4'd0) begin fails++; $display("[TB] FAIL single_raddr: got %0d want 0", bus.mem_raddr); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_early_valid: got %b want 0", bus.out_valid); end
        advance();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL single_out_valid: got %b want 1", bus.out_valid); end
        tests++; if (bus.out_data !== 16'hA001) begin fails++; $display("[TB] FAIL single_out_data: got %h want a001", bus.out_data); end
        tests++; if (bus.level !== 5'd1) begin fails++; $display("[TB] FAIL single_level: got %0d want 1", bus.level); end
        advance();
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        advance();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tests++; if (bus.level !== 5'd0) begin fails++; $display("[TB] FAIL single_drained_level: got %0d want 0", bus.level); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_drained_valid: got %b want 0", bus.out_valid); end
        advance();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, word_t'(i), 1'b0, 1'b0, 1'b1);
            tests++; if (bus.in_ready !== (i < 17)) begin fails++; $display("[TB] FAIL fill_in_ready[%0d]: got %b want %b", i, bus.in_ready, (i < 17)); end
            tests++; if (bus.mem_we !== (i < 17)) begin fails++; $display("[TB] FAIL fill_mem_we[%0d]: got %b want %b", i, bus.mem_we, (i < 17)); end
            advance();
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tests++; if (bus.level !== 5'd17) begin fails++; $display("[TB] FAIL fill_level: got %0d want 17", bus.level); end
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL fill_out_valid: got %b want 1", bus.out_valid); end
        tests++; if (bus.out_data !== 16'h0000) begin fails++; $display("[TB] FAIL fill_out_data: got %h want 0000", bus.out_data); end
        advance();
    endtask

    task automatic test_full_pop();
        drive(1'b1, 16'h0011, 1'b1, 1'b0, 1'b1);
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("[TB] FAIL fullpop_in_ready: got %b want 0", bus.in_ready); end
        tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("[TB] FAIL fullpop_mem_we: got %b want 0", bus.mem_we); end
        advance();
        drive(1'b1, 16'h0011, 1'b0, 1'b0, 1'b1);
        tests++; if (bus.out_data !== 16'h0001) begin fails++; $display("[TB] FAIL fullpop_out_data: got %h want 0001", bus.out_data); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL fullpop_in_ready_next: got %b want 1", bus.in_ready); end
        tests++; if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 16'h0011) begin fails++; $display("[TB] FAIL fullpop_push: got we=%b data=%h want we=1 data=0011", bus.mem_we, bus.mem_wdata); end
        advance();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tests++; if (bus.level !== 5'd17) begin fails++; $display("[TB] FAIL fullpop_level: got %0d want 17", bus.level); end
        advance();
    endtask

    task automatic test_drain();
        int n = 0;
        while ((mcnt != 0 || mov) && n < 40) begin
            drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
            tests++; if (bus.out_valid !== mov) begin fails++; $display("[TB] FAIL drain_valid[%0d]: got %b want %b", n, bus.out_valid, mov); end
            if (mov) begin
                tests++; if (bus.out_data !== sb[0]) begin fails++; $display("[TB] FAIL drain_data[%0d]: got %h want %h", n, bus.out_data, sb[0]); end
            end
            advance();
            n++;
        end
        tests++; if (n >= 40) begin fails++; $display("[TB] FAIL drain_timeout: got %0d cycles want under 40", n); end
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tests++; if (bus.level !== 5'd0) begin fails++; $display("[TB] FAIL drain_level: got %0d want 0", bus.level); end
        advance();
    endtask

    task automatic test_wrap();
        int received = 0;
        word_t want;
        for (int c = 0; c < 42; c++) begin
            drive(c < 40, word_t'(32'h1000 + c), 1'b1, 1'b0, 1'b1);
            tests++; if (bus.out_valid !== (c >= 2)) begin fails++; $display("[TB] FAIL wrap_valid[%0d]: got %b want %b", c, bus.out_valid, (c >= 2)); end
            if (c >= 2) begin
                want = word_t'(32'h1000 + c - 2);
                tests++; if (bus.out_data !== want || sb.size() == 0 || sb[0] !== want) begin fails++; $display("[TB] FAIL wrap_data[%0d]: got %h want %h", c, bus.out_data, want); end
            end
            if (bus.out_valid === 1'b1) received++;
            advance();
        end
        tests++; if (received != 40) begin fails++; $display("[TB] FAIL wrap_count: got %0d want 40", received); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, word_t'(32'h5000 + i), 1'b0, 1'b0, 1'b1);
            advance();
        end
        drive(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b1);
        tests++; if (bus.level !== 5'd5) begin fails++; $display("[TB] FAIL flush_pre_level: got %0d want 5", bus.level); end
        tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("[TB] FAIL flush_mem_we: got %b want 0", bus.mem_we); end
        advance();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tests++; if (bus.level !== 5'd0) begin fails++; $display("[TB] FAIL flush_level: got %0d want 0", bus.level); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_out_valid: got %b want 0", bus.out_valid); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL flush_in_ready: got %b want 1", bus.in_ready); end
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
            tests++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000) begin fails++; $display("[TB] FAIL flush_stale[%0d]: got valid=%b data=%h want valid=0 data=0000", k, bus.out_valid, bus.out_data); end
            advance();
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        test_reset();
        test_single();
        test_fill();
        test_full_pop();
        test_drain();
        test_wrap();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl16.md
# fifo_ctrl16

Streaming FIFO controller on the opposite side of the 16x16 negedge-sampled dual-port SRAM. Owns the write and read address/enable ports of that RAM, presents a valid/ready push interface and a valid/ready pop interface, and registers the pop data. It is the standard buffer between producers and consumers in the MiniLab datapath, with 17 words of total capacity: 16 in the RAM plus 1 output register.

## Interface
- DATA_W, 16, word width; must equal the RAM data width.
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W = 16.
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- flush  in  1  synchronous clear of all contents; same effect as reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller accepts a word this cycle.
- in_data  in  DATA_W  word to push.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer takes out_data this cycle.
- out_data  out  DATA_W  registered head-of-FIFO word.
- level  out  5  words held in total, 0..17 (RAM count + out_valid); width is 5 bits, so 17 fits.
- mem_we, mem_waddr[ADDR_W], mem_wdata[DATA_W]  out  to the RAM write port.
- mem_re, mem_raddr[ADDR_W]  out  to the RAM read port.
- mem_rdata  in  DATA_W  RAM read data; updates on negedge clk.

## Operation
- State: wptr, rptr (ADDR_W bits, wrap naturally 15->0), ram_cnt (0..16), out_valid, out_data.
- push = in_valid & in_ready, with in_ready = (ram_cnt != 16).
  - in_ready does not depend on out_ready. There is no same-cycle pass-through.
- load = (ram_cnt != 0) & (~out_valid | out_ready).
- The mem_* outputs are combinational from state and inputs:
  - mem_we = push, mem_waddr = wptr, mem_wdata = in_data.
  - mem_re = load, mem_raddr = rptr.
- On posedge, when not in reset or flush:
  - wptr += push; rptr += load; ram_cnt += push − load.
  - If load: out_data <= mem_rdata and out_valid <= 1.
  - Else if out_ready: out_valid <= 0.
- A word written in cycle n is counted in ram_cnt only from cycle n+1. It is therefore never read on the same negedge it is written, so the RAM read-during-write-returns-old-data behaviour never matters.
- Full: ram_cnt = 16 forces in_ready = 0; push is ignored even if out_ready = 1 that cycle.
- Empty: ram_cnt = 0 forces load = 0; out_valid drops after the last word is popped.
- level = ram_cnt + out_valid.

## Timing
- Reset (rst_n = 0 at posedge) and flush (flush = 1 at posedge) both clear:
  - wptr = rptr = 0, ram_cnt = 0, out_valid = 0, out_data = 0.
  - Resulting outputs: in_ready = 1, level = 0, mem_we = mem_re = 0.
- A push or pop coincident with reset or flush is discarded. Reset takes priority over flush.
- Reset mid-stream loses all contents. RAM contents are not cleared; they are stale but unreachable.
- Latency from an accepted push in cycle n to out_valid/out_data:
  - RAM write at negedge of cycle n.
  - load in cycle n+1; RAM read at negedge of n+1.
  - out_valid = 1 from cycle n+2.
- Throughput is 1 word/cycle with out_ready held high.
- mem_* outputs must settle within the first half-cycle, since the RAM samples at negedge. in_valid, in_data and out_ready are half-cycle paths.

## Structure
- Shared package fifo_pkg holds:
  - localparams DATA_W = 16, ADDR_W = 4, DEPTH = 16, LVL_W = 5.
  - a typedef for the word type.
- No sub-module inside the controller. The RAM is instantiated alongside it by the parent wrapper.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 -> out_valid = 0, in_ready = 1, level = 0, mem_we = 0, out_data = 0x0000.
- Single word: push 0xA001 in cycle 0, out_ready = 0.
  - Cycle 0: mem_we = 1, waddr = 0.
  - Cycle 1: mem_re = 1, raddr = 0.
  - Cycle 2: out_valid = 1, out_data = 0xA001, level = 1.
- Fill: push 0x0000..0x0011 back-to-back with out_ready = 0 -> words 0x0000..0x0010 accepted, in_ready = 0 once ram_cnt = 16, 0x0011 held off, level = 17, out_data = 0x0000.
- Full plus pop: at level 17, assert in_valid and out_ready together.
  - That cycle: push refused.
  - Next cycle: out_data = 0x0001, in_ready = 1.
  - Push accepted the cycle after.
- Wrap and order: stream 40 words (0x1000 + i) with out_ready = 1 -> output identical and in order, first at cycle 2, then one per cycle; wptr/rptr wrap twice.
- Flush: at level 5, pulse flush with in_valid = 1 -> next cycle level = 0, out_valid = 0, in_ready = 1; the pushed word never appears at out_data.
